// File: rtl/imem_loader.sv
// Writable instruction memory filled by a big-endian byte-stream loader; combinational CPU fetch port.
// Optional IMEM_CHECKSUM_EN adds a trailing mod-256 checksum byte to the load frame.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    input  logic [31:0] addr,
    output logic [31:0] val
);

    localparam int unsigned PTR_W     = ADDR_W + 1;
    localparam logic [31:0] BYTE_SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM
    } state_t;

    state_t             state;
    logic [7:0]         len_hi;
    logic [PTR_W-1:0]   nwords;
    logic [PTR_W-1:0]   ptr;
    logic [1:0]         bcnt;
    logic [23:0]        word_sr;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               acc_c;
    logic               wr_en_c;
    logic [31:0]        wr_word_c;
    logic [15:0]        len_c;
    logic               last_word_c;
    logic [ADDR_W-1:0]  rd_idx_c;

    assign acc_c       = s_valid && s_ready;
    assign wr_en_c     = (state == S_DATA) && acc_c && (bcnt == 2'd3);
    assign wr_word_c   = {word_sr, s_data};
    assign len_c       = {len_hi, s_data};
    assign last_word_c = (PTR_W'(ptr + PTR_W'(1)) == nwords);
    assign cpu_hold    = busy;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_next_c;
    assign csum_next_c = 8'(csum + s_data);
`endif

    // Load sequencer; s_ready/busy follow state so they are only updated on transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            len_hi  <= 8'd0;
            nwords  <= '0;
            ptr     <= '0;
            bcnt    <= 2'd0;
            word_sr <= 24'd0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            csum    <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_req) begin
                        state   <= S_LEN_HI;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        ptr     <= '0;
                        bcnt    <= 2'd0;
`ifdef IMEM_CHECKSUM_EN
                        csum    <= 8'd0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (acc_c) begin
                        len_hi <= s_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (acc_c) begin
                        if (len_c == 16'd0) begin
                            state   <= S_IDLE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (32'(len_c) > 32'(DEPTH_WORDS)) begin
                            state   <= S_IDLE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            nwords <= PTR_W'(len_c);
                            state  <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (acc_c) begin
`ifdef IMEM_CHECKSUM_EN
                        csum <= csum_next_c;
`endif
                        bcnt <= 2'(bcnt + 2'd1);
                        if (bcnt != 2'd3) begin
                            word_sr <= {word_sr[15:0], s_data};
                        end else begin
                            ptr <= PTR_W'(ptr + PTR_W'(1));
                            if (last_word_c) begin
`ifdef IMEM_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state   <= S_IDLE;
                                s_ready <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_CHECKSUM_EN
                S_CSUM: begin
                    if (acc_c) begin
                        state   <= S_IDLE;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (s_data == csum) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Word store; reset clears the whole program image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= 32'd0;
            end
        end else if (wr_en_c) begin
            mem[ptr[ADDR_W-1:0]] <= wr_word_c;
        end
    end

    assign rd_idx_c = addr[ADDR_W+1:2];
    assign val      = (addr < BYTE_SPAN) ? mem[rd_idx_c] : 32'd0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default depth; checksum cases when IMEM_CHECKSUM_EN is defined).
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [31:0] addr;
    logic [31:0] val;

    int n_cmp;
    int n_bad;
    logic [7:0] frm [$];

    imem_loader #(.DEPTH_WORDS(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .addr     (addr),
        .val      (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, val, exp);
    endtask

    // Called at a negedge; presents one byte after gap idle cycles, returns at the following negedge
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        check("s_ready_during_load", 32'(s_ready), 32'd1);
        check("no_early_done", 32'(done), 32'd0);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic start_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("busy_after_req", 32'(busy), 32'd1);
        check("hold_after_req", 32'(cpu_hold), 32'd1);
        check("ready_after_req", 32'(s_ready), 32'd1);
        check("err_cleared_by_req", 32'(err), 32'd0);
    endtask

    task automatic run_frame(input int gap, input logic exp_done, input logic exp_err);
        start_load();
        foreach (frm[i]) send_byte(frm[i], gap);
        check("done_after_last", 32'(done), 32'(exp_done));
        check("busy_after_last", 32'(busy), 32'd0);
        check("ready_after_last", 32'(s_ready), 32'd0);
        check("err_after_last", 32'(err), 32'(exp_err));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        load_req = 1'b0;
        s_data   = 8'd0;
        s_valid  = 1'b0;
        addr     = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        read_chk("reset_val0", 32'h0, 32'h0);
        check("reset_ready", 32'(s_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // Two-word program, continuous stream
        frm = '{8'h00, 8'h02, 8'h27, 8'hBD, 8'hFF, 8'hE0, 8'hAF, 8'hBF, 8'h00, 8'h1C};
`ifdef IMEM_CHECKSUM_EN
        frm.push_back(8'h4D);
`endif
        run_frame(0, 1'b1, 1'b0);
        read_chk("word0", 32'h0, 32'h27BDFFE0);
        read_chk("word1", 32'h4, 32'hAFBF001C);
        read_chk("word1_low_bits_ignored", 32'h7, 32'hAFBF001C);
        read_chk("word2_untouched", 32'h8, 32'h0);
        read_chk("out_of_range", 32'h100, 32'h0);
        read_chk("last_in_range", 32'hFC, 32'h0);

        // Same frame with 3 idle cycles before every byte, over a cleared store
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        read_chk("cleared_before_gap", 32'h0, 32'h0);
        run_frame(3, 1'b1, 1'b0);
        read_chk("gap_word0", 32'h0, 32'h27BDFFE0);
        read_chk("gap_word1", 32'h4, 32'hAFBF001C);

        // Oversized length
        frm = '{8'h00, 8'h41};
        run_frame(0, 1'b0, 1'b1);
        read_chk("len_err_word0_kept", 32'h0, 32'h27BDFFE0);
        repeat (2) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);

        // New load clears err, then reset mid-data
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        read_chk("partial_word0", 32'h0, 32'h11223344);
        read_chk("partial_word1_old", 32'h4, 32'hAFBF001C);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        read_chk("rst_word0", 32'h0, 32'h0);
        read_chk("rst_word1", 32'h4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef IMEM_CHECKSUM_EN
        frm.push_back(8'h14);
`endif
        run_frame(1, 1'b1, 1'b0);
        read_chk("after_rst_word0", 32'h0, 32'h12345678);
        read_chk("after_rst_word1", 32'h4, 32'h0);

        // Zero-length frame: immediate done, nothing written
        frm = '{8'h00, 8'h00};
        run_frame(0, 1'b1, 1'b0);
        read_chk("zero_len_word0", 32'h0, 32'h12345678);

`ifdef IMEM_CHECKSUM_EN
        frm = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        run_frame(0, 1'b1, 1'b0);
        read_chk("csum_ok_word0", 32'h0, 32'h00000001);
        frm = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02};
        run_frame(0, 1'b1, 1'b0);
        frm = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
        run_frame(0, 1'b0, 1'b1);
        read_chk("csum_bad_word0", 32'h0, 32'h00000001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory that replaces the fixed program image. A byte-stream loader writes big-endian 32-bit words into a word-addressed store, and the CPU fetch port reads that store combinationally with the same addr/val behaviour as the fetch path expects. `cpu_hold` keeps the core stalled while a program is being written, so a new program can be loaded without resynthesis.

## Interface
Parameters:
- `DEPTH_WORDS`, default 64: number of 32-bit words; byte address range is 0 to DEPTH_WORDS*4-1.
- `ADDR_W`, default $clog2(DEPTH_WORDS): word-index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_req`  in  1  starts a load; sampled only in IDLE.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `busy`  out  1  load in progress.
- `cpu_hold`  out  1  equals `busy`; stalls the core.
- `done`  out  1  one-cycle pulse when a load completes successfully.
- `err`  out  1  sticky error flag.
- `addr`  in  32  CPU fetch byte address.
- `val`  out  32  instruction word, combinational from `addr`.

## Operation
- Byte transfer: a byte is accepted on a rising edge where `s_valid && s_ready`.
- Frame format, in order:
  - LEN_HI, LEN_LO: 16-bit big-endian word count N.
  - N×4 data bytes. The first byte of each word goes to bits 31:24.
  - With IMEM_CHECKSUM_EN: one checksum byte follows the data.
- States:
  - IDLE: `s_ready`=0. `load_req`=1 → LEN_HI, clear `err`, word pointer ← 0.
  - LEN_HI → LEN_LO on an accepted byte.
  - LEN_LO on an accepted byte:
    - N=0 → IDLE, pulse `done`, no writes.
    - N>DEPTH_WORDS → IDLE, set `err`, no writes.
    - Otherwise → DATA.
  - DATA: a 2-bit byte counter assembles the word. On the 4th accepted byte, mem[ptr] ← word and ptr increments.
  - After word N: → CSUM if the macro is defined, else → IDLE and pulse `done`.
  - CSUM: on an accepted byte → IDLE. Pulse `done` if it matches, else set `err`.
- Words already written stay written after an error or an abort; there is no rollback.
- Read port:
  - word index = `addr[ADDR_W+1:2]`; `addr[1:0]` is ignored.
  - `addr` ≥ DEPTH_WORDS*4 → `val`=32'h00000000.
  - Reads are legal during a load and return current contents.
- `load_req` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, all memory words 0, `s_ready`=0, `busy`=0, `cpu_hold`=0, `done`=0, `err`=0, pointer and counters 0.
- `load_req` at edge k → `busy`=1 and `s_ready`=1 from after edge k. `s_ready` is registered and depends only on state (1 in LEN_HI, LEN_LO, DATA and CSUM).
- Memory write on the edge that accepts the 4th byte; `val` reflects the new word from that edge onward.
- Final accepted byte at edge m → `busy` falls and `done` is high for exactly the cycle after edge m; both are updated on edge m.
- `err` is set on the edge that detects the error and holds until the next accepted `load_req`.
- Gaps in `s_valid` stall the FSM with no state change and no timeout.
- `rst` mid-load: immediately IDLE, outputs to reset values, memory cleared to 0.
- Pointer never wraps, because N ≤ DEPTH_WORDS is checked before DATA.

## Configuration
- `IMEM_CHECKSUM_EN` defined:
  - CSUM state is present.
  - Expected value = 8-bit sum, mod 256, of all 4N data bytes.
  - Mismatch sets `err` and suppresses `done`.
  - For N=0 the CSUM state is skipped.
- Not defined: no CSUM state and no adder logic; the frame ends after the last data byte.

## Test plan
- Reset, then `addr`=0x00 → `val`=0x00000000; `s_ready`=0, `busy`=0.
- `load_req`, bytes 00 02 27 BD FF E0 AF BF 00 1C, `s_valid` always high:
  - `val`@0x00=0x27BDFFE0, `val`@0x04=0xAFBF001C.
  - `done` pulses once, 1 cycle after the last byte; `busy` falls on the same edge.
- Same frame with `s_valid` low for 3 cycles between every byte → identical memory result; `done` 1 cycle after the final byte.
- Length 00 41 (65) with DEPTH_WORDS=64 → `err`=1, `busy`=0, memory unchanged, no `done`. A following `load_req` clears `err`.
- `rst` asserted after 6 data bytes → `busy`=0 immediately; `val`@0x00=0; a following full load succeeds.
- With IMEM_CHECKSUM_EN, N=1, data 00 00 00 01:
  - checksum 01 → `done`.
  - checksum 02 → `err`=1 and `val`@0x00=0x00000001 still written.
